// File: rtl/csa_mp_add_sched.sv
// Two-requester multi-precision adder scheduler. Each accepted request is
// WORDS x 32-bit wide and is evaluated LS word first on one shared 32-bit carry-skip adder.

module carryskip_adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  // Eight 4-bit ripple blocks. A block whose bits all propagate passes its carry-in straight through.
  always_comb begin : skip_chain
    logic c_blk;
    logic c_rip;
    logic p_blk;
    sum   = '0;
    c_blk = cin;
    for (int unsigned blk = 0; blk < 8; blk++) begin
      c_rip = c_blk;
      p_blk = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
        sum[4*blk+i] = a[4*blk+i] ^ b[4*blk+i] ^ c_rip;
        c_rip        = (a[4*blk+i] & b[4*blk+i]) | ((a[4*blk+i] ^ b[4*blk+i]) & c_rip);
        p_blk        = p_blk & (a[4*blk+i] ^ b[4*blk+i]);
      end
      c_blk = p_blk ? c_blk : c_rip;
    end
    cout = c_blk;
  end
endmodule

module csa_mp_add_sched #(
  parameter int unsigned WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [32*WORDS-1:0]   req0_a,
  input  logic [32*WORDS-1:0]   req0_b,
  input  logic                  req0_cin,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [32*WORDS-1:0]   req1_a,
  input  logic [32*WORDS-1:0]   req1_b,
  input  logic                  req1_cin,
  output logic                  req1_ready,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_id,
  output logic [32*WORDS-1:0]   res_sum,
  output logic                  res_cout,
  output logic                  busy
);
  localparam int unsigned KW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_e;

  state_e                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic                    carry_q, carry_d;
  logic                    last_grant_q, last_grant_d;
  logic [WORDS-1:0][31:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic                    cin_q, cin_d;
  logic                    id_q, id_d;
  logic                    cout_q, cout_d;

  logic                    gnt_sel;
  logic                    accept;
  logic                    last_word;
  logic [31:0]             add_sum;
  logic                    add_cin;
  logic                    add_cout;

  assign last_word = (k_q == KW'(WORDS - 1));
  assign add_cin   = (k_q == '0) ? cin_q : carry_q;
  assign accept    = req0_ready | req1_ready;

  carryskip_adder32 u_adder (
    .a    (a_q[k_q]),
    .b    (b_q[k_q]),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      k_q          <= '0;
      carry_q      <= 1'b0;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      cin_q        <= 1'b0;
      id_q         <= 1'b0;
      sum_q        <= '0;
      cout_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      carry_q      <= carry_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cin_q        <= cin_d;
      id_q         <= id_d;
      sum_q        <= sum_d;
      cout_q       <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = ADD;
      ADD:     if (last_word) state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Ready is gated by rst_n so neither requester sees a handshake while reset is held.
  always_comb begin
    gnt_sel    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    req0_ready = rst_n && (state_q == IDLE) && req0_valid && !gnt_sel;
    req1_ready = rst_n && (state_q == IDLE) && req1_valid &&  gnt_sel;
    res_valid  = (state_q == DONE);
    busy       = (state_q != IDLE);
  end

  always_comb begin
    k_d          = k_q;
    carry_d      = carry_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    cin_d        = cin_q;
    id_d         = id_q;
    sum_d        = sum_q;
    cout_d       = cout_q;
    if (accept) begin
      a_d          = gnt_sel ? req1_a   : req0_a;
      b_d          = gnt_sel ? req1_b   : req0_b;
      cin_d        = gnt_sel ? req1_cin : req0_cin;
      id_d         = gnt_sel;
      last_grant_d = gnt_sel;
      k_d          = '0;
    end else if (state_q == ADD) begin
      sum_d[k_q] = add_sum;
      carry_d    = add_cout;
      k_d        = k_q + KW'(1);
      if (last_word) cout_d = add_cout;
    end
  end

  assign res_id   = id_q;
  assign res_sum  = sum_q;
  assign res_cout = cout_q;
endmodule

// File: tb/tb_csa_mp_add_sched.sv
// Directed self-checking bench for csa_mp_add_sched with WORDS = 4.

module tb_csa_mp_add_sched;
  localparam int unsigned WORDS = 4;
  localparam int unsigned N     = 32 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_cin, req1_cin;
  logic         req0_ready, req1_ready;
  logic         res_valid, res_ready, res_id, res_cout, busy;
  logic [N-1:0] res_sum;

  csa_mp_add_sched #(.WORDS(WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_id     (res_id),
    .res_sum    (res_sum),
    .res_cout   (res_cout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t         vecs [10];
  logic [N-1:0] rr_a [4];
  logic [N-1:0] rr_b [4];
  logic         rr_c [4];
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
  endfunction

  // Called at the negedge after the accept edge; returns at the negedge where res_valid is seen.
  task automatic wait_result(output int lat);
    bit done;
    lat  = 0;
    done = 0;
    while (!done) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (res_valid) done = 1;
      else if (lat >= 40) begin
        n_checks++;
        n_fail++;
        $display("FAIL result_timeout: res_valid still low after %0d cycles, required within 40", lat);
        done = 1;
      end
    end
  endtask

  task automatic run_check(input string tag, input logic exp_id, input logic [N-1:0] a,
                           input logic [N-1:0] b, input logic cin);
    int         lat;
    logic [N:0] m;
    wait_result(lat);
    m = model(a, b, cin);
    check({tag, "_latency"}, 256'(lat), 256'(4));
    check({tag, "_sum"},     256'(res_sum), 256'(m[N-1:0]));
    check({tag, "_cout"},    256'(res_cout), 256'(m[N]));
    check({tag, "_id"},      256'(res_id), 256'(exp_id));
    check({tag, "_busy"},    256'(busy), 256'(1));
  endtask

  initial begin
    vecs[0] = '{'1, 128'h1, 1'b0, '0, 1'b1};
    vecs[1] = '{128'h00000000_FFFFFFFF_00000000_FFFFFFFF, '0, 1'b1,
                128'h00000000_FFFFFFFF_00000001_00000000, 1'b0};
    vecs[2] = '{'0, '0, 1'b0, '0, 1'b0};
    vecs[3] = '{'0, '0, 1'b1, 128'h1, 1'b0};
    vecs[4] = '{'1, '1, 1'b1, '1, 1'b1};
    vecs[5] = '{128'h80000000_00000000_00000000_00000000,
                128'h80000000_00000000_00000000_00000000, 1'b0, '0, 1'b1};
    vecs[6] = '{128'h00000001_00000002_00000003_00000004,
                128'h10000000_20000000_30000000_40000000, 1'b0,
                128'h10000001_20000002_30000003_40000004, 1'b0};
    vecs[7] = '{128'h0000000F_FFFFFFFF_FFFFFFFF_FFFFFFF0, 128'h10, 1'b0,
                128'h00000010_00000000_00000000_00000000, 1'b0};
    vecs[8] = '{128'h12345678_9ABCDEF0_0F0F0F0F_F0F0F0F0,
                128'hEDCBA987_6543210F_F0F0F0F0_0F0F0F10, 1'b0, '0, 1'b1};
    vecs[9] = '{128'h7FFFFFFF, 128'h1, 1'b1, 128'h80000001, 1'b0};

    rr_a[0] = 128'h01234567_89ABCDEF_FEDCBA98_76543210; rr_b[0] = 128'hFFFFFFFF_00000001_FFFFFFFF_00000001; rr_c[0] = 1'b1;
    rr_a[1] = 128'hDEADBEEF_CAFEBABE_0BADF00D_8BADF00D; rr_b[1] = 128'h21524110_35014541_F4520FF2_74520FF3; rr_c[1] = 1'b0;
    rr_a[2] = 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A; rr_b[2] = 128'h5A5A5A5A_A5A5A5A5_5A5A5A5A_A5A5A5A5; rr_c[2] = 1'b1;
    rr_a[3] = 128'h00000000_00000000_FFFFFFFF_FFFFFFFF; rr_b[3] = 128'h00000000_00000001_00000000_00000001; rr_c[3] = 1'b0;

    // Reset with both requesters asserting valid.
    rst_n      = 1'b0;
    res_ready  = 1'b0;
    req0_valid = 1'b1; req0_a = rr_a[0]; req0_b = rr_b[0]; req0_cin = rr_c[0];
    req1_valid = 1'b1; req1_a = rr_a[1]; req1_b = rr_b[1]; req1_cin = rr_c[1];
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_res_valid", 256'(res_valid), 256'(0));
    check("rst_res_sum",   256'(res_sum), 256'(0));
    check("rst_res_cout",  256'(res_cout), 256'(0));
    check("rst_res_id",    256'(res_id), 256'(0));
    check("rst_busy",      256'(busy), 256'(0));
    check("rst_ready0",    256'(req0_ready), 256'(0));
    check("rst_ready1",    256'(req1_ready), 256'(0));
    rst_n = 1'b1;
    #1;

    // Round robin with both valid continuously: 0,1,0,1.
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic g;
      g = 1'(i % 2);
      check($sformatf("rr%0d_ready0", i), 256'(req0_ready), 256'(!g));
      check($sformatf("rr%0d_ready1", i), 256'(req1_ready), 256'(g));
      @(posedge clk);
      @(negedge clk);
      if (i + 2 < 4) begin
        if (g) begin req1_a = rr_a[i+2]; req1_b = rr_b[i+2]; req1_cin = rr_c[i+2]; end
        else   begin req0_a = rr_a[i+2]; req0_b = rr_b[i+2]; req0_cin = rr_c[i+2]; end
      end
      run_check($sformatf("rr%0d", i), g, rr_a[i], rr_b[i], rr_c[i]);
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Table of directed vectors, alternating requesters; operands scrambled after acceptance.
    for (int i = 0; i < 10; i++) begin
      logic g;
      int   lat;
      g = 1'(i % 2);
      if (g) begin req1_valid = 1'b1; req1_a = vecs[i].a; req1_b = vecs[i].b; req1_cin = vecs[i].cin; end
      else   begin req0_valid = 1'b1; req0_a = vecs[i].a; req0_b = vecs[i].b; req0_cin = vecs[i].cin; end
      #1;
      check($sformatf("v%0d_ready", i), 256'(g ? req1_ready : req0_ready), 256'(1));
      @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = {$urandom, $urandom, $urandom, $urandom}; req0_b = {$urandom, $urandom, $urandom, $urandom};
      req1_a = {$urandom, $urandom, $urandom, $urandom}; req1_b = {$urandom, $urandom, $urandom, $urandom};
      req0_cin = ~vecs[i].cin; req1_cin = ~vecs[i].cin;
      wait_result(lat);
      check($sformatf("v%0d_latency", i), 256'(lat), 256'(4));
      check($sformatf("v%0d_sum", i),  256'(res_sum), 256'(vecs[i].sum));
      check($sformatf("v%0d_cout", i), 256'(res_cout), 256'(vecs[i].cout));
      check($sformatf("v%0d_id", i),   256'(res_id), 256'(g));
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_idle_busy", i),  256'(busy), 256'(0));
      check($sformatf("v%0d_idle_valid", i), 256'(res_valid), 256'(0));
    end

    // Back-pressure: 10 stalled cycles with both requesters pending.
    begin
      logic [N:0] m;
      int         lat;
      int         stall_bad;
      res_ready  = 1'b0;
      req0_valid = 1'b1; req0_a = rr_a[2]; req0_b = rr_b[3]; req0_cin = 1'b1;
      #1;
      check("bp_ready0", 256'(req0_ready), 256'(1));
      @(posedge clk);
      @(negedge clk);
      m = model(rr_a[2], rr_b[3], 1'b1);
      req0_a = rr_a[0];
      req1_valid = 1'b1; req1_a = rr_a[3]; req1_b = rr_b[0]; req1_cin = 1'b0;
      wait_result(lat);
      check("bp_latency", 256'(lat), 256'(4));
      stall_bad = 0;
      for (int c = 0; c < 10; c++) begin
        @(posedge clk);
        @(negedge clk);
        if (res_valid !== 1'b1 || res_sum !== m[N-1:0] || res_cout !== m[N] || res_id !== 1'b0 ||
            busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0)
          stall_bad++;
      end
      check("bp_stall_stable", 256'(stall_bad), 256'(0));
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_release_valid", 256'(res_valid), 256'(0));
      check("bp_release_busy",  256'(busy), 256'(0));
      check("bp_release_ready0", 256'(req0_ready), 256'(0));
      check("bp_release_ready1", 256'(req1_ready), 256'(1));
      @(posedge clk);
      @(negedge clk);
      check("bp_next_busy", 256'(busy), 256'(1));
      req0_valid = 1'b0; req1_valid = 1'b0;
      run_check("bp_next", 1'b1, rr_a[3], rr_b[0], 1'b0);
      @(posedge clk);
      @(negedge clk);
    end

    // Reset asserted during the second ADD cycle.
    begin
      int saw_valid;
      req0_valid = 1'b1; req0_a = '1; req0_b = '1; req0_cin = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req1_valid = 1'b1;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mr_busy",      256'(busy), 256'(0));
      check("mr_res_valid", 256'(res_valid), 256'(0));
      check("mr_res_sum",   256'(res_sum), 256'(0));
      check("mr_res_cout",  256'(res_cout), 256'(0));
      check("mr_res_id",    256'(res_id), 256'(0));
      check("mr_ready0",    256'(req0_ready), 256'(0));
      check("mr_ready1",    256'(req1_ready), 256'(0));
      saw_valid = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (res_valid !== 1'b0) saw_valid++;
      end
      check("mr_no_valid", 256'(saw_valid), 256'(0));
      req0_a = vecs[8].a; req0_b = vecs[8].b; req0_cin = vecs[8].cin;
      rst_n = 1'b1;
      #1;
      check("mr_after_ready0", 256'(req0_ready), 256'(1));
      check("mr_after_ready1", 256'(req1_ready), 256'(0));
      @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      run_check("mr_after", 1'b0, vecs[8].a, vecs[8].b, vecs[8].cin);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
